// File: rtl/change_dispenser_if.sv
// Request and coin-ejector handshakes between the vending controller and the change dispenser.
interface change_dispenser_if #(
    parameter int unsigned AMT_W = 32
) ();
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             coin_valid;
    logic [AMT_W-1:0] coin_value;
    logic             coin_ready;

    modport master (
        output req_valid, req_amount, coin_ready,
        input  req_ready, coin_valid, coin_value
    );

    modport slave (
        input  req_valid, req_amount, coin_ready,
        output req_ready, coin_valid, coin_value
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout (largest denomination first) with per-denomination stock and shortfall report.
module change_dispenser #(
    parameter int unsigned AMT_W      = 32,
    parameter int unsigned STOCK_W    = 8,
    parameter int unsigned DENOM_HI   = 10,
    parameter int unsigned DENOM_MID  = 5,
    parameter int unsigned DENOM_LO   = 1,
    parameter int unsigned INIT_STOCK = 20
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus,
    input  logic               refill_valid,
    input  logic [1:0]         refill_sel,
    input  logic [STOCK_W-1:0] refill_count,
    output logic               done,
    output logic               short,
    output logic [AMT_W-1:0]   shortfall,
    output logic [7:0]         coins_paid,
    output logic [STOCK_W-1:0] stock_hi,
    output logic [STOCK_W-1:0] stock_mid,
    output logic [STOCK_W-1:0] stock_lo
);
    localparam logic [AMT_W-1:0]   D_HI   = AMT_W'(DENOM_HI);
    localparam logic [AMT_W-1:0]   D_MID  = AMT_W'(DENOM_MID);
    localparam logic [AMT_W-1:0]   D_LO   = AMT_W'(DENOM_LO);
    localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(INIT_STOCK);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EMIT, S_DONE, S_FAIL} state_t;
    typedef enum logic [1:0] {DEN_HI = 2'd0, DEN_MID = 2'd1, DEN_LO = 2'd2} den_t;

    state_t           state;
    den_t             den_q;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] coin_value_q;
    logic             coin_valid_q;
    logic             req_ready_q;
    logic             emit_hs;
    logic [STOCK_W-1:0] hi_n, mid_n, lo_n;

    assign bus.req_ready  = req_ready_q;
    assign bus.coin_valid = coin_valid_q;
    assign bus.coin_value = coin_value_q;

    assign emit_hs = (state == S_EMIT) && bus.coin_ready;

    // Refill and ejection may hit the same counter in one cycle; fold both into one saturating sum.
    function automatic logic [STOCK_W-1:0] stock_next(
        input logic [STOCK_W-1:0] cur,
        input logic               add_en,
        input logic [STOCK_W-1:0] cnt,
        input logic               dec
    );
        logic [STOCK_W:0] sum;
        sum = {1'b0, cur} + (add_en ? {1'b0, cnt} : '0) - {{STOCK_W{1'b0}}, dec};
        return sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
    endfunction

    always_comb begin
        hi_n  = stock_next(stock_hi,  refill_valid && refill_sel == 2'd0, refill_count,
                           emit_hs && den_q == DEN_HI);
        mid_n = stock_next(stock_mid, refill_valid && refill_sel == 2'd1, refill_count,
                           emit_hs && den_q == DEN_MID);
        lo_n  = stock_next(stock_lo,  refill_valid && refill_sel == 2'd2, refill_count,
                           emit_hs && den_q == DEN_LO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            den_q        <= DEN_HI;
            remaining    <= '0;
            coin_value_q <= '0;
            coin_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            done         <= 1'b0;
            short        <= 1'b0;
            shortfall    <= '0;
            coins_paid   <= '0;
            stock_hi     <= S_INIT;
            stock_mid    <= S_INIT;
            stock_lo     <= S_INIT;
        end else begin
            stock_hi  <= hi_n;
            stock_mid <= mid_n;
            stock_lo  <= lo_n;
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        remaining   <= bus.req_amount;
                        coins_paid  <= '0;
                        shortfall   <= '0;
                        short       <= 1'b0;
                        req_ready_q <= 1'b0;
                        if (bus.req_amount == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (remaining >= D_HI && stock_hi != '0) begin
                        coin_value_q <= D_HI;
                        den_q        <= DEN_HI;
                        coin_valid_q <= 1'b1;
                        state        <= S_EMIT;
                    end else if (remaining >= D_MID && stock_mid != '0) begin
                        coin_value_q <= D_MID;
                        den_q        <= DEN_MID;
                        coin_valid_q <= 1'b1;
                        state        <= S_EMIT;
                    end else if (remaining >= D_LO && stock_lo != '0) begin
                        coin_value_q <= D_LO;
                        den_q        <= DEN_LO;
                        coin_valid_q <= 1'b1;
                        state        <= S_EMIT;
                    end else begin
                        state     <= S_FAIL;
                        done      <= 1'b1;
                        short     <= 1'b1;
                        shortfall <= remaining;
                    end
                end
                S_EMIT: begin
                    if (bus.coin_ready) begin
                        coin_valid_q <= 1'b0;
                        remaining    <= remaining - coin_value_q;
                        if (coins_paid != 8'hFF) coins_paid <= coins_paid + 8'd1;
                        if (remaining == coin_value_q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_DONE, S_FAIL: begin
                    done        <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
